// File: rtl/n_bit_sequential_multiplier.sv
// Iterative shift-add multiplier retiring K multiplier bits per cycle, with valid/ready on both sides.
// Optional SEQ_MULT_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are all zero.
module n_bit_sequential_multiplier #(
  parameter int unsigned N = 8,
  parameter int unsigned K = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     A,
  input  logic [N-1:0]     B,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   PROD
);

  localparam int unsigned C  = N / K;
  localparam int unsigned PW = 2 * N;
  localparam int unsigned CW = $clog2(C + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   a_sh_q, a_sh_d;
  logic [N-1:0]    b_sh_q, b_sh_d;
  logic            neg_q, neg_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   iter_q, iter_d;
  logic [PW-1:0]   prod_q, prod_d;
  logic            out_valid_q, out_valid_d;
  logic [N-1:0]    a_mag, b_mag;
  logic            busy_done;

  assign in_ready  = (state_q == IDLE) && !reset;
  assign out_valid = out_valid_q;
  assign PROD      = prod_q;

  // Operand magnitudes; the most negative value maps to 2^(N-1), which fits in N unsigned bits.
  assign a_mag = (is_signed && A[N-1]) ? (~A + N'(1)) : A;
  assign b_mag = (is_signed && B[N-1]) ? (~B + N'(1)) : B;

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    neg_d       = neg_q;
    acc_d       = acc_q;
    iter_d      = iter_q;
    prod_d      = prod_q;
    busy_done   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_sh_d  = PW'(a_mag);
          b_sh_d  = b_mag;
          neg_d   = is_signed && (A[N-1] ^ B[N-1]);
          acc_d   = '0;
          iter_d  = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Multiplicand is kept pre-shifted, so it already carries the K*iter weighting.
        acc_d  = acc_q + a_sh_q * PW'(b_sh_q[K-1:0]);
        a_sh_d = a_sh_q << K;
        b_sh_d = b_sh_q >> K;
        iter_d = iter_q + CW'(1);
`ifdef SEQ_MULT_EARLY_TERM_EN
        busy_done = (b_sh_d == '0) || (iter_q == CW'(C - 1));
`else
        busy_done = (iter_q == CW'(C - 1));
`endif
        if (busy_done) begin
          prod_d  = neg_q ? (~acc_d + PW'(1)) : acc_d;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      neg_q       <= 1'b0;
      acc_q       <= '0;
      iter_q      <= '0;
      prod_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      neg_q       <= neg_d;
      acc_q       <= acc_d;
      iter_q      <= iter_d;
      prod_q      <= prod_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_n_bit_sequential_multiplier.sv
// Randomised bench for n_bit_sequential_multiplier: an N=8/K=1 instance for directed cases
// and an N=16/K=4 instance for random traffic, both against an arithmetic reference model.
module tb_n_bit_sequential_multiplier;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        iv8, ir8, s8, ov8, or8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic        iv16, ir16, s16, ov16, or16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  int errors = 0;
  int checks = 0;

  n_bit_sequential_multiplier #(.N(8), .K(1)) u_dut8 (
    .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8),
    .is_signed(s8), .out_valid(ov8), .out_ready(or8), .PROD(p8));

  n_bit_sequential_multiplier #(.N(16), .K(4)) u_dut16 (
    .clk(clk), .reset(reset), .in_valid(iv16), .in_ready(ir16), .A(a16), .B(b16),
    .is_signed(s16), .out_valid(ov16), .out_ready(or16), .PROD(p16));

  task automatic check(input string tag, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  // Reference model: interpret operands as integers, multiply, wrap to 2N bits
  function automatic longint as_int(input int n, input longint v, input bit s);
    longint pw = longint'(1) << n;
    if (s && v >= (pw >> 1)) return v - pw;
    return v;
  endfunction

  function automatic longint golden(input int n, input longint a, input longint b, input bit s);
    longint p = as_int(n, a, s) * as_int(n, b, s);
    return p & ((longint'(1) << (2 * n)) - 1);
  endfunction

  function automatic int exp_lat(input int n, input int k, input longint b, input bit s);
`ifdef SEQ_MULT_EARLY_TERM_EN
    longint bm = as_int(n, b, s);
    int bits = 0;
    if (bm < 0) bm = -bm;
    while (bm != 0) begin
      bits++;
      bm = bm >> 1;
    end
    if (bits == 0) return 1;
    return (bits + k - 1) / k;
`else
    return n / k;
`endif
  endfunction

  task automatic drive(input int sel, input longint a, input longint b, input bit s, input bit v);
    if (sel == 0) begin
      a8 = 8'(a); b8 = 8'(b); s8 = s; iv8 = v;
    end else begin
      a16 = 16'(a); b16 = 16'(b); s16 = s; iv16 = v;
    end
  endtask

  task automatic set_or(input int sel, input bit v);
    if (sel == 0) or8 = v; else or16 = v;
  endtask

  function automatic bit g_ir(input int sel);
    return (sel == 0) ? ir8 : ir16;
  endfunction

  function automatic bit g_ov(input int sel);
    return (sel == 0) ? ov8 : ov16;
  endfunction

  function automatic longint g_prod(input int sel);
    return (sel == 0) ? longint'(p8) : longint'(p16);
  endfunction

  // One full transaction: accept, count latency, optional stall (with ignored in_valid), drain
  task automatic run_op(input int sel, input longint a, input longint b, input bit s,
                        input int stall, input bit noise);
    int n = (sel == 0) ? 8 : 16;
    int k = (sel == 0) ? 1 : 4;
    int lat = 0;
    longint exp = golden(n, a, b, s);
    @(negedge clk);
    check("in_ready_idle", longint'(g_ir(sel)), 1);
    drive(sel, a, b, s, 1'b1);
    @(negedge clk);
    drive(sel, a, b, s, 1'b0);
    while (!g_ov(sel) && lat < 100) begin
      check("in_ready_busy", longint'(g_ir(sel)), 0);
      set_or(sel, 1'($urandom_range(0, 1)));
      @(negedge clk);
      lat++;
    end
    set_or(sel, 1'b0);
    check("latency", longint'(lat), longint'(exp_lat(n, k, b, s)));
    check("prod", g_prod(sel), exp);
    check("in_ready_done", longint'(g_ir(sel)), 0);
    for (int i = 0; i < stall; i++) begin
      drive(sel, 1, 2, 1'b0, noise);
      @(negedge clk);
      check("hold_valid", longint'(g_ov(sel)), 1);
      check("hold_prod", g_prod(sel), exp);
      check("hold_in_ready", longint'(g_ir(sel)), 0);
    end
    drive(sel, a, b, s, 1'b0);
    set_or(sel, 1'b1);
    @(negedge clk);
    set_or(sel, 1'b0);
    check("drained_valid", longint'(g_ov(sel)), 0);
    check("in_ready_after", longint'(g_ir(sel)), 1);
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 1'b0, 1'b0);
    drive(1, 0, 0, 1'b0, 1'b0);
    or8 = 1'b0;
    or16 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid8", longint'(ov8), 0);
    check("rst_prod8", longint'(p8), 0);
    check("rst_in_ready8", longint'(ir8), 0);
    check("rst_out_valid16", longint'(ov16), 0);
    check("rst_prod16", longint'(p16), 0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", longint'(ir8), 1);

    run_op(0, 200, 100, 1'b0, 0, 1'b0);
    run_op(0, 8'h80, 8'h80, 1'b1, 0, 1'b0);
    run_op(0, 8'hFD, 7, 1'b1, 1, 1'b0);
    run_op(0, 15, 15, 1'b0, 5, 1'b1);

    // Abort mid-operation: previous PROD is 225, so a clear to 0 is observable
    @(negedge clk);
    drive(0, 255, 255, 1'b0, 1'b1);
    @(negedge clk);
    drive(0, 255, 255, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_out_valid", longint'(ov8), 0);
    check("abort_prod", longint'(p8), 0);
    check("abort_in_ready", longint'(ir8), 0);
    @(negedge clk);
    check("abort_in_ready_hold", longint'(ir8), 0);
    reset = 1'b0;
    run_op(0, 3, 5, 1'b0, 0, 1'b0);

    run_op(0, 9, 6, 1'b0, 0, 1'b0);
    run_op(0, 77, 1, 1'b0, 0, 1'b0);
    run_op(0, 77, 0, 1'b0, 0, 1'b0);
    run_op(0, 3, 8'h80, 1'b0, 0, 1'b0);
    run_op(0, 8'h80, 8'h7F, 1'b1, 0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      run_op(1, longint'($urandom_range(0, 65535)), longint'($urandom_range(0, 65535)),
             1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    run_op(1, 16'h8000, 16'h8000, 1'b1, 0, 1'b0);
    run_op(1, 16'hFFFF, 16'hFFFF, 1'b0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
